// File: rtl/fft_frame_sequencer.sv
// Frame sequencer around a 16-point FFT: gathers FIR samples into frames, hands each frame
// to the FFT, then scans the returned bins for the largest magnitude.
module fft_frame_sequencer #(
  parameter int unsigned DW   = 16,
  parameter int unsigned NPTS = 16
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   flush,
  input  logic                   fir_valid,
  input  logic [DW-1:0]          fir_d,
  output logic                   stp_valid,
  output logic [32*NPTS-1:0]     stp_data,
  input  logic                   fft_valid,
  input  logic [32*NPTS-1:0]     fft_data,
  output logic                   freq_valid,
  output logic [3:0]             freq,
  output logic                   overrun,
  output logic [15:0]            frame_cnt
);

  localparam logic [3:0] LastIdx = 4'(NPTS - 1);

  typedef enum logic {StIdle, StScan} state_e;

  // Collector state
  logic [3:0]          wcnt_q, wcnt_d;
  logic [DW-1:0]       sbuf_q [NPTS];
  logic                stp_valid_q, stp_valid_d;
  logic [32*NPTS-1:0]  stp_data_q, stp_data_d;

  // Scanner state
  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [32*NPTS-1:0]  rbuf_q;
  logic                rbuf_load;
  logic [32:0]         best_mag_q, best_mag_d;
  logic [3:0]          best_idx_q, best_idx_d;
  logic [3:0]          freq_q, freq_d;
  logic                freq_valid_q, freq_valid_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  // Magnitude of the bin currently under the scan pointer
  logic [31:0]         bin_word;
  logic signed [15:0]  bin_re, bin_im;
  logic signed [31:0]  re_sq, im_sq;
  logic [32:0]         mag;
  logic                is_better;
  logic                scan_last;
  logic                accept;

  // Collector next-state: count samples, publish a frame on the 16th
  always_comb begin
    wcnt_d      = wcnt_q;
    stp_valid_d = 1'b0;
    stp_data_d  = stp_data_q;
    if (flush) begin
      wcnt_d = '0;
    end else if (fir_valid) begin
      if (wcnt_q == LastIdx) begin
        for (int k = 0; k < int'(NPTS) - 1; k++) begin
          stp_data_d[32*k +: 32] = {sbuf_q[k], 16'h0000};
        end
        // The last sample bypasses the buffer so the frame is ready one cycle sooner
        stp_data_d[32*(NPTS-1) +: 32] = {fir_d, 16'h0000};
        stp_valid_d = 1'b1;
        wcnt_d      = '0;
      end else begin
        wcnt_d = wcnt_q + 4'd1;
      end
    end
  end

  // Sample buffer needs no reset; wcnt decides which entries are meaningful
  always_ff @(posedge CLK) begin
    if (fir_valid && !flush) begin
      sbuf_q[wcnt_q] <= fir_d;
    end
  end

  // Collector registers; stp_data survives flush because the FFT reads it combinationally
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wcnt_q      <= '0;
      stp_valid_q <= 1'b0;
      stp_data_q  <= '0;
    end else begin
      wcnt_q      <= wcnt_d;
      stp_valid_q <= stp_valid_d;
      stp_data_q  <= stp_data_d;
    end
  end

  // Squared magnitude of the current bin, 33 bits so two full-scale squares cannot wrap
  always_comb begin
    bin_word  = rbuf_q[{idx_q, 5'b0} +: 32];
    bin_re    = $signed(bin_word[31:16]);
    bin_im    = $signed(bin_word[15:0]);
    re_sq     = bin_re * bin_re;
    im_sq     = bin_im * bin_im;
    mag       = {1'b0, re_sq} + {1'b0, im_sq};
    is_better = mag > best_mag_q;
    scan_last = (state_q == StScan) && (idx_q == LastIdx);
    accept    = fft_valid && ((state_q == StIdle) || scan_last);
  end

  // Scanner next-state: walk bins, track the strict maximum, report on the last bin
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    best_mag_d   = best_mag_q;
    best_idx_d   = best_idx_q;
    freq_d       = freq_q;
    freq_valid_d = 1'b0;
    overrun_d    = overrun_q;
    frame_cnt_d  = frame_cnt_q;
    rbuf_load    = 1'b0;
    if (flush) begin
      state_d     = StIdle;
      idx_d       = '0;
      best_mag_d  = '0;
      best_idx_d  = '0;
      freq_d      = '0;
      overrun_d   = 1'b0;
      frame_cnt_d = '0;
    end else begin
      if (state_q == StScan) begin
        if (is_better) begin
          best_mag_d = mag;
          best_idx_d = idx_q;
        end
        idx_d = idx_q + 4'd1;
        if (scan_last) begin
          freq_d       = is_better ? idx_q : best_idx_q;
          freq_valid_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 16'd1;
          state_d      = StIdle;
        end else if (fft_valid) begin
          // Result arriving mid-scan is dropped; the running scan is left alone
          overrun_d = 1'b1;
        end
      end
      if (accept) begin
        rbuf_load  = 1'b1;
        idx_d      = '0;
        best_mag_d = '0;
        best_idx_d = '0;
        state_d    = StScan;
      end
    end
  end

  // Result buffer is only read while scanning, so it carries no reset
  always_ff @(posedge CLK) begin
    if (rbuf_load) begin
      rbuf_q <= fft_data;
    end
  end

  // Scanner registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      best_mag_q   <= '0;
      best_idx_q   <= '0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      best_mag_q   <= best_mag_d;
      best_idx_q   <= best_idx_d;
      freq_q       <= freq_d;
      freq_valid_q <= freq_valid_d;
      overrun_q    <= overrun_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign stp_valid  = stp_valid_q;
  assign stp_data   = stp_data_q;
  assign freq_valid = freq_valid_q;
  assign freq       = freq_q;
  assign overrun    = overrun_q;
  assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: scanner vector table, overrun, flush, a live
// integer DFT on the collector path, and asynchronous reset mid-frame.
module tb_fft_frame_sequencer;

  logic         CLK = 1'b0;
  logic         RST;
  logic         flush;
  logic         fir_valid;
  logic [15:0]  fir_d;
  logic         stp_valid;
  logic [511:0] stp_data;
  logic         fft_valid;
  logic [511:0] fft_data;
  logic         freq_valid;
  logic [3:0]   freq;
  logic         overrun;
  logic [15:0]  frame_cnt;

  logic         attach;
  logic         fft_valid_drv;
  logic [511:0] fft_data_drv;
  logic         fft_vld_q = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  // cos(2*pi*m/16) scaled by 2^14; sin(m) = cos(m+12)
  localparam int COS_TAB [16] = '{16384, 15137, 11585, 6270, 0, -6270, -11585, -15137,
                                  -16384, -15137, -11585, -6270, 0, 6270, 11585, 15137};
  // round(256*cos(2*pi*3n/16))
  localparam int XS [16] = '{256, 98, -181, -237, 0, 237, 181, -98,
                             -256, -98, 181, 237, 0, -237, -181, 98};

  fft_frame_sequencer dut (
    .CLK        (CLK),
    .RST        (RST),
    .flush      (flush),
    .fir_valid  (fir_valid),
    .fir_d      (fir_d),
    .stp_valid  (stp_valid),
    .stp_data   (stp_data),
    .fft_valid  (fft_valid),
    .fft_data   (fft_data),
    .freq_valid (freq_valid),
    .freq       (freq),
    .overrun    (overrun),
    .frame_cnt  (frame_cnt)
  );

  always #5 CLK = ~CLK;

  // Integer DFT standing in for the combinational FFT; truncation toward zero keeps
  // conjugate bins exactly mirrored.
  function automatic logic [511:0] dft(input logic [511:0] d);
    logic [511:0]       r;
    logic signed [15:0] s;
    int                 sr, si, m;
    r = '0;
    for (int k = 0; k < 16; k++) begin
      sr = 0;
      si = 0;
      for (int n = 0; n < 16; n++) begin
        s  = d[32*n+16 +: 16];
        m  = (k * n) % 16;
        sr = sr + int'(s) * COS_TAB[m];
        si = si - int'(s) * COS_TAB[(m + 12) % 16];
      end
      sr = sr / 16384;
      si = si / 16384;
      r[32*k +: 32] = {sr[15:0], si[15:0]};
    end
    return r;
  endfunction

  // The FFT registers only its valid
  always @(posedge CLK) fft_vld_q <= stp_valid;

  assign fft_valid = attach ? fft_vld_q : fft_valid_drv;
  assign fft_data  = attach ? dft(stp_data) : fft_data_drv;

  typedef struct {
    string        name;
    logic [511:0] data;
    logic [3:0]   exp_freq;
  } vec_t;

  vec_t vecs [6];

  function automatic logic [511:0] put(input logic [511:0] d, input int k,
                                       input logic [15:0] re, input logic [15:0] im);
    d[32*k +: 32] = {re, im};
    return d;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    int lat, nfv, nstp, fv_at, stp_at;
    int fv_t [8];
    logic [3:0] fv_f [8];
    logic [511:0] d;

    // Vector table: bins and the index the scan must report
    d = '0; vecs[0] = '{"bin9", put(d, 9, 16'sd100, -16'sd100), 4'd9};
    d = put('0, 2, 16'sd50, 16'sd0); vecs[1] = '{"tie2_11", put(d, 11, 16'sd50, 16'sd0), 4'd2};
    vecs[2] = '{"zero", '0, 4'd0};
    d = put('0, 0, 16'sd1, 16'sd1); vecs[3] = '{"bin15", put(d, 15, 16'sd0, -16'sd32768), 4'd15};
    d = put('0, 0, -16'sd32768, -16'sd32768);
    vecs[4] = '{"fullscale", put(d, 5, 16'sd32767, 16'sd32767), 4'd0};
    d = put('0, 4, 16'sd3, 16'sd4);
    d = put(d, 7, 16'sd5, 16'sd0);
    d = put(d, 10, 16'sd0, 16'sd6);
    vecs[5] = '{"mixed", put(d, 12, -16'sd4, -16'sd3), 4'd10};

    RST = 1'b1; flush = 1'b0; fir_valid = 1'b0; fir_d = '0;
    attach = 1'b0; fft_valid_drv = 1'b0; fft_data_drv = '0;
    repeat (2) @(posedge CLK);
    #1;
    check("rst_stp_valid", stp_valid, 0);
    check("rst_stp_data", (stp_data == '0), 1);
    check("rst_freq_valid", freq_valid, 0);
    check("rst_freq", freq, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    @(negedge CLK) RST = 1'b0;
    tick();

    // Standalone scanner vectors
    for (int i = 0; i < 6; i++) begin
      fft_data_drv  = vecs[i].data;
      fft_valid_drv = 1'b1;
      tick();
      fft_valid_drv = 1'b0;
      fft_data_drv  = {16{32'h7fff_7fff}};  // junk after E0 must not leak into the scan
      lat = 0;
      for (int c = 1; c <= 40; c++) begin
        tick();
        if (freq_valid) begin lat = c; break; end
      end
      check({vecs[i].name, "_latency"}, lat, 16);
      check({vecs[i].name, "_freq"}, freq, vecs[i].exp_freq);
      check({vecs[i].name, "_frame_cnt"}, frame_cnt, i + 1);
      tick();
      check({vecs[i].name, "_strobe_width"}, freq_valid, 0);
    end
    check("hold_freq", freq, 4'd10);

    // Overrun: second result mid-scan is dropped
    fft_data_drv = vecs[0].data; fft_valid_drv = 1'b1;
    tick();  // E0
    fft_valid_drv = 1'b0;
    repeat (4) tick();  // E1..E4
    check("ovr_before", overrun, 0);
    fft_data_drv = vecs[5].data; fft_valid_drv = 1'b1;
    tick();  // E5
    fft_valid_drv = 1'b0;
    tick();  // E6
    check("ovr_set", overrun, 1);
    nfv = 0; fv_at = 0;
    for (int c = 7; c <= 40; c++) begin
      tick();
      if (freq_valid) begin nfv++; fv_at = c; check("ovr_freq", freq, 9); end
    end
    check("ovr_strobes", nfv, 1);
    check("ovr_strobe_at", fv_at, 16);
    check("ovr_frame_cnt", frame_cnt, 7);
    check("ovr_sticky", overrun, 1);

    // Flush while the scanner sits at idx 8
    fft_data_drv = vecs[5].data; fft_valid_drv = 1'b1;
    tick();  // E0
    fft_valid_drv = 1'b0;
    repeat (8) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_overrun", overrun, 0);
    check("flush_frame_cnt", frame_cnt, 0);
    check("flush_freq", freq, 0);
    nfv = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (freq_valid) nfv++;
    end
    check("flush_no_strobe", nfv, 0);

    // Collector with the DFT attached, 64 continuous samples of a bin-3 cosine
    attach = 1'b1;
    nstp = 0; nfv = 0; stp_at = -1;
    for (int c = 0; c < 100; c++) begin
      fir_valid = (c < 64);
      fir_d     = 16'(XS[c % 16]);
      tick();
      if (stp_valid) begin
        nstp++;
        if (stp_at < 0) begin
          stp_at = c;
          check("stp_word0", stp_data[31:0], 32'h0100_0000);
          check("stp_word3", stp_data[127:96], 32'hff13_0000);
          check("stp_word15", stp_data[511:480], 32'h0062_0000);
        end
      end
      if (freq_valid) begin
        if (nfv < 8) begin fv_t[nfv] = c; fv_f[nfv] = freq; end
        nfv++;
      end
    end
    fir_valid = 1'b0;
    check("stream_stp_count", nstp, 4);
    check("stream_stp_at", stp_at, 15);
    check("stream_fv_count", nfv, 4);
    if (nfv == 4) begin
      check("stream_fv_first", fv_t[0], 33);
      for (int i = 0; i < 4; i++) check("stream_freq", fv_f[i], 3);
      for (int i = 1; i < 4; i++) check("stream_spacing", fv_t[i] - fv_t[i-1], 16);
    end
    check("stream_frame_cnt", frame_cnt, 4);
    check("stream_overrun", overrun, 0);
    attach = 1'b0;

    // Asynchronous reset after 7 samples
    for (int c = 0; c < 7; c++) begin
      fir_valid = 1'b1;
      fir_d     = 16'(500 + c);
      tick();
    end
    fir_valid = 1'b0;
    #2 RST = 1'b1;
    #1;
    check("arst_frame_cnt", frame_cnt, 0);
    check("arst_stp_data", stp_data[31:0], 0);
    @(negedge CLK) RST = 1'b0;
    nstp = 0; nfv = 0; stp_at = -1;
    for (int c = 0; c < 25; c++) begin
      fir_valid = (c < 16);
      fir_d     = 16'(1000 + c);
      tick();
      if (stp_valid) begin
        nstp++;
        if (stp_at < 0) begin
          stp_at = c;
          check("arst_word0", stp_data[31:0], {16'd1000, 16'h0000});
          check("arst_word15", stp_data[511:480], {16'd1015, 16'h0000});
        end
      end
      if (freq_valid) nfv++;
    end
    fir_valid = 1'b0;
    check("arst_stp_count", nstp, 1);
    check("arst_stp_at", stp_at, 15);
    check("arst_no_freq", nfv, 0);
    check("arst_overrun", overrun, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Absolute time bound so the bench always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit, expected completion");
    $fatal(1);
  end

endmodule
